// File: rtl/hazard_controller_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_controller_pkg;

  localparam int REG_ADDR_W            = 5;
  localparam int MEM_TIMEOUT_DEFAULT   = 16;
  localparam int CONTROL_SIGNALS_WIDTH = 5;
  localparam int WAIT_CNT_W            = 8;
  localparam int PERF_CNT_W            = 32;

  // One bit is enough for the two-state sequencer.
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Field order matches the packed output concatenation in the top.
  typedef struct packed {
    logic stall;
    logic flush;
    logic bubble;
    logic pc_hold;
    logic mem_hold;
  } ctrl_t;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  function automatic logic is_load_use(
    input logic                  ex_valid,
    input logic                  ex_mem_read,
    input logic [REG_ADDR_W-1:0] ex_rd_addr,
    input logic                  id_valid,
    input logic [REG_ADDR_W-1:0] id_rs1_addr,
    input logic [REG_ADDR_W-1:0] id_rs2_addr
  );
    return ex_valid & ex_mem_read & (ex_rd_addr != '0) & id_valid &
           ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller.
// master = pipeline (drives stage status, receives controls),
// slave  = hazard controller.
interface hazard_controller_if ();
  import hazard_controller_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  ex_valid;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  stall;
  logic                  flush;
  logic                  bubble;
  logic                  pc_hold;
  logic                  mem_hold;
  logic                  mem_timeout;
  logic [PERF_CNT_W-1:0] stall_count;
  logic [PERF_CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr,
    output ex_valid, ex_mem_read, ex_rd_addr, ex_branch_taken,
    output mem_req, mem_ready,
    input  stall, flush, bubble, pc_hold, mem_hold, mem_timeout,
    input  stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr,
    input  ex_valid, ex_mem_read, ex_rd_addr, ex_branch_taken,
    input  mem_req, mem_ready,
    output stall, flush, bubble, pc_hold, mem_hold, mem_timeout,
    output stall_count, flush_count
  );

endinterface

// File: rtl/hazard_controller_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32
  import hazard_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic [PERF_CNT_W-1:0] count
);

  // Count enabled cycles, holding once the maximum is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use and branch hazards plus data-memory
// wait sequencing with a timeout.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_RUN      | normal flow; load-use / branch hazards resolved here
//   ST_MEM_WAIT | data access outstanding; pipeline frozen until ready
//
// The wait timer is a down-counter: loaded with MEM_TIMEOUT-1 on entry to
// ST_MEM_WAIT and the wait is abandoned when it reaches zero with the memory
// still not ready, which is the MEM_TIMEOUT-th cycle spent waiting.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  hazard_controller_if.slave hz
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_e                state_q;
  state_e                state_d;
  logic [WAIT_CNT_W-1:0] wait_rem_q;
  logic [WAIT_CNT_W-1:0] wait_rem_d;
  logic                  timeout_q;
  logic                  timeout_set;
  logic                  load_use;
  logic                  branch_flush;
  logic                  mem_miss;
  ctrl_t                 ctrl;

  assign load_use = is_load_use(hz.ex_valid, hz.ex_mem_read, hz.ex_rd_addr,
                                hz.id_valid, hz.id_rs1_addr, hz.id_rs2_addr);
  assign branch_flush = hz.ex_valid & hz.ex_branch_taken;
  assign mem_miss     = hz.mem_req & ~hz.mem_ready;

  // State, wait timer and sticky timeout flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_rem_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_rem_q <= wait_rem_d;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Next-state and wait-timer update.
  always_comb begin
    state_d     = state_q;
    wait_rem_d  = wait_rem_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_miss) begin
          state_d    = ST_MEM_WAIT;
          wait_rem_d = WAIT_LOAD;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d    = ST_RUN;
          wait_rem_d = '0;
        end else if (wait_rem_q == '0) begin
          state_d     = ST_RUN;
          wait_rem_d  = '0;
          timeout_set = 1'b1;
        end else begin
          wait_rem_d = wait_rem_q - 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_rem_d = '0;
      end
    endcase
  end

  // Pipeline control outputs; forced low for as long as reset is applied.
  // A memory miss freezes the whole pipeline, EX included, so it also
  // outranks branch and load-use handling on the cycle it is first seen:
  // the held branch is then taken on the first cycle back in ST_RUN.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (mem_miss) begin
            ctrl.stall    = 1'b1;
            ctrl.pc_hold  = 1'b1;
            ctrl.mem_hold = 1'b1;
          end else if (branch_flush) begin
            ctrl.flush = 1'b1;
          end else if (load_use) begin
            ctrl.stall   = 1'b1;
            ctrl.pc_hold = 1'b1;
            ctrl.bubble  = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!hz.mem_ready) begin
            ctrl.stall    = 1'b1;
            ctrl.pc_hold  = 1'b1;
            ctrl.mem_hold = 1'b1;
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign {hz.stall, hz.flush, hz.bubble, hz.pc_hold, hz.mem_hold} =
         CONTROL_SIGNALS_WIDTH'(ctrl);
  assign hz.mem_timeout = timeout_q;

  sat_counter32 u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl.stall),
    .count (hz.stall_count)
  );

  sat_counter32 u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl.flush),
    .count (hz.flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller.
module tb_hazard_controller;

  localparam int T = 4;

  logic clk;
  logic reset;
  hazard_controller_if hz ();

  hazard_controller #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  string tag = "init";

  // reference model state
  bit          m_waiting;
  int          m_wait_cycles;
  bit          m_timeout;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  // last sampled DUT outputs
  logic s_stall, s_flush, s_bubble, s_pc_hold, s_mem_hold;

  typedef struct {
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       exv;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [4:0] exp; // {stall, flush, bubble, pc_hold, mem_hold}
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic exv, input logic mr, input logic [4:0] rd,
                        input logic br, input logic req, input logic rdy);
    hz.id_valid        = idv;
    hz.id_rs1_addr     = rs1;
    hz.id_rs2_addr     = rs2;
    hz.ex_valid        = exv;
    hz.ex_mem_read     = mr;
    hz.ex_rd_addr      = rd;
    hz.ex_branch_taken = br;
    hz.mem_req         = req;
    hz.mem_ready       = rdy;
  endtask

  task automatic model_reset();
    m_waiting     = 0;
    m_wait_cycles = 0;
    m_timeout     = 0;
    m_stall_cnt   = 0;
    m_flush_cnt   = 0;
  endtask

  // Expected controls from the rules: memory wait first, then branch, then load-use.
  task automatic model_outputs(output logic s, output logic f, output logic b,
                               output logic p, output logic m);
    bit lu;
    s = 0; f = 0; b = 0; p = 0; m = 0;
    lu = hz.ex_valid && hz.ex_mem_read && (hz.ex_rd_addr != 0) && hz.id_valid &&
         ((hz.ex_rd_addr == hz.id_rs1_addr) || (hz.ex_rd_addr == hz.id_rs2_addr));
    if (m_waiting) begin
      if (!hz.mem_ready) begin s = 1; p = 1; m = 1; end
    end else if (hz.mem_req && !hz.mem_ready) begin
      s = 1; p = 1; m = 1;
    end else if (hz.ex_valid && hz.ex_branch_taken) begin
      f = 1;
    end else if (lu) begin
      s = 1; p = 1; b = 1;
    end
  endtask

  task automatic model_edge(input logic s, input logic f);
    if (s && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
    if (f && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
    if (m_waiting) begin
      if (hz.mem_ready) begin
        m_waiting = 0;
      end else if (m_wait_cycles == T) begin
        m_waiting = 0;
        m_timeout = 1;
      end else begin
        m_wait_cycles++;
      end
    end else if (hz.mem_req && !hz.mem_ready) begin
      m_waiting     = 1;
      m_wait_cycles = 1;
    end
  endtask

  // One clock cycle: compare everything mid-cycle, then advance model at the edge.
  task automatic step();
    logic es, ef, eb, ep, em;
    @(negedge clk);
    model_outputs(es, ef, eb, ep, em);
    s_stall = hz.stall; s_flush = hz.flush; s_bubble = hz.bubble;
    s_pc_hold = hz.pc_hold; s_mem_hold = hz.mem_hold;
    chk("stall",       hz.stall,       es);
    chk("flush",       hz.flush,       ef);
    chk("bubble",      hz.bubble,      eb);
    chk("pc_hold",     hz.pc_hold,     ep);
    chk("mem_hold",    hz.mem_hold,    em);
    chk("mem_timeout", hz.mem_timeout, m_timeout);
    chk("stall_count", hz.stall_count, m_stall_cnt);
    chk("flush_count", hz.flush_count, m_flush_cnt);
    @(posedge clk);
    model_edge(es, ef);
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset with the current inputs still applied; outputs must drop at once.
  task automatic do_reset();
    string save;
    save = tag;
    tag = "reset";
    reset = 1'b1;
    #2;
    chk("stall",       hz.stall,       0);
    chk("flush",       hz.flush,       0);
    chk("bubble",      hz.bubble,      0);
    chk("pc_hold",     hz.pc_hold,     0);
    chk("mem_hold",    hz.mem_hold,    0);
    chk("mem_timeout", hz.mem_timeout, 0);
    chk("stall_count", hz.stall_count, 0);
    chk("flush_count", hz.flush_count, 0);
    idle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    tag = save;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            idv rs1 rs2 exv mr rd  br req rdy  {s,f,b,p,m}
    tbl[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'b10110};
    tbl[2]  = '{1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b10110};
    tbl[3]  = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[4]  = '{1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[5]  = '{1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[6]  = '{1'b1, 5'd3, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[7]  = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b01000};
    tbl[8]  = '{1'b1, 5'd9, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'b01000};
    tbl[9]  = '{1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, 5'b10110};
    tbl[10] = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[11] = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 5'b01000};

    reset = 1'b1;
    idle();
    model_reset();
    #1;
    do_reset();

    // table of single-cycle RUN vectors
    tag = "table";
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].idv, tbl[i].rs1, tbl[i].rs2, tbl[i].exv, tbl[i].mr,
             tbl[i].rd, tbl[i].br, tbl[i].req, tbl[i].rdy);
      step();
      chk($sformatf("vec%0d", i), {s_stall, s_flush, s_bubble, s_pc_hold, s_mem_hold},
          {27'd0, tbl[i].exp});
    end
    idle();
    step();

    // load-use on rs2, then x0 load, then branch + load-use
    do_reset();
    tag = "load_use";
    set_in(1, 5'd1, 5'd5, 1, 1, 5'd5, 0, 0, 0);
    step();
    chk("lu_stall", s_stall, 1); chk("lu_bubble", s_bubble, 1); chk("lu_pc_hold", s_pc_hold, 1);
    idle();
    step();
    chk("lu_after", s_stall, 0);
    chk("lu_count", hz.stall_count, 1);
    tag = "x0_load";
    set_in(1, 5'd0, 5'd2, 1, 1, 5'd0, 0, 0, 0);
    step();
    chk("x0_stall", s_stall, 0); chk("x0_bubble", s_bubble, 0);
    tag = "br_lu";
    set_in(1, 5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    step();
    chk("br_flush", s_flush, 1); chk("br_stall", s_stall, 0);
    chk("br_bubble", s_bubble, 0); chk("br_pc_hold", s_pc_hold, 0);
    idle();
    step();
    chk("br_flush_count", hz.flush_count, 1);

    // memory wait: 4 stalled cycles then ready
    do_reset();
    tag = "mem_wait";
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mw_stall%0d", i), s_stall, 1);
      chk($sformatf("mw_hold%0d", i), s_mem_hold, 1);
    end
    hz.mem_ready = 1'b1;
    step();
    chk("mw_ready_stall", s_stall, 0);
    idle();
    step();
    chk("mw_count", hz.stall_count, 4);
    chk("mw_timeout", hz.mem_timeout, 0);

    // branch held in EX during a wait is taken on the first RUN cycle
    tag = "mw_branch";
    set_in(0, 0, 0, 1, 0, 0, 1, 1, 0);
    step();
    chk("mwb_flush0", s_flush, 0);
    hz.mem_ready = 1'b1;
    step();
    chk("mwb_flush1", s_flush, 0);
    hz.mem_req = 1'b0;
    hz.mem_ready = 1'b0;
    step();
    chk("mwb_flush2", s_flush, 1);
    idle();
    step();

    // timeout after MEM_TIMEOUT cycles in MEM_WAIT
    do_reset();
    tag = "timeout";
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("to_stall%0d", i), s_stall, 1);
    end
    idle();
    step();
    chk("to_run_stall", s_stall, 0);
    chk("to_flag", hz.mem_timeout, 1);
    chk("to_count", hz.stall_count, 5);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    chk("to_zero_wait", s_stall, 0);
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("to_sticky", hz.mem_timeout, 1);

    // reset in the middle of a wait
    do_reset();
    tag = "reset_mid";
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    chk("rm_waiting", s_mem_hold, 1);
    hz.ex_valid = 1'b1;
    hz.ex_branch_taken = 1'b1;
    do_reset();
    tag = "reset_mid";
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    chk("rm_no_stall", s_stall, 0);
    idle();
    step();

    // randomized traffic against the model
    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset();
        tag = "random";
      end
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The module SHALL have the parameter MEM_TIMEOUT, default 16, giving the maximum number of cycles spent in MEM_WAIT before the wait is abandoned (legal range 2..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rs1_addr, id_rs2_addr  input  5 each  source register addresses of the ID instruction.
REQ-006 ex_valid  input  1  EX stage holds a valid instruction.
REQ-007 ex_mem_read  input  1  EX instruction is a load.
REQ-008 ex_rd_addr  input  5  destination register of the EX instruction.
REQ-009 ex_branch_taken  input  1  branch/jump resolved in EX redirects the PC.
REQ-010 mem_req  input  1  MEM stage issues a data-memory access this cycle.
REQ-011 mem_ready  input  1  data memory completes the access this cycle.
REQ-012 stall  output  1  hold IF/ID and ID/EX registers.
REQ-013 flush  output  1  clear IF/ID and ID/EX registers.
REQ-014 bubble  output  1  force id_valid_in and control inputs of ID/EX to zero.
REQ-015 pc_hold  output  1  PC register keeps its value.
REQ-016 mem_hold  output  1  hold EX/MEM and MEM/WB registers.
REQ-017 mem_timeout  output  1  sticky flag: a memory wait expired.
REQ-018 stall_count, flush_count  output  32 each  performance counters.

Function
REQ-019 The hazard unit SHALL detect load-use as ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr).
- It SHALL be combinational: stall=1, pc_hold=1 and bubble=1 in the same cycle, for exactly one cycle per hazard.
REQ-020 ex_valid & ex_branch_taken SHALL give flush=1 in the same cycle, for one cycle; pc_hold=0.
REQ-021 When a branch flush and a load-use hazard occur in the same cycle, flush SHALL win and stall, bubble and pc_hold SHALL be 0.
REQ-022 The FSM SHALL have the states RUN and MEM_WAIT, encoded in a 1-bit register.
REQ-023 In RUN, mem_req & !mem_ready SHALL assert stall, pc_hold and mem_hold combinationally and move the FSM to MEM_WAIT at the next edge.
- The wait counter SHALL be loaded to 1.
REQ-024 In MEM_WAIT, stall, pc_hold and mem_hold SHALL remain 1.
- mem_ready SHALL deassert all three in that same cycle and return the FSM to RUN.
- Otherwise the wait counter SHALL increment by 1.
REQ-025 In MEM_WAIT, when the wait counter equals MEM_TIMEOUT and mem_ready=0:
- mem_timeout SHALL be set at the next edge and stay set until reset.
- The FSM SHALL return to RUN.
REQ-026 In MEM_WAIT, the memory wait SHALL take priority: flush, bubble and load-use stall SHALL be suppressed.
- A branch flush pending in EX SHALL be taken on the first RUN cycle, since EX is held.
REQ-027 stall_count SHALL increment by 1 on every cycle with stall=1.
REQ-028 flush_count SHALL increment by 1 on every cycle with flush=1.
REQ-029 Both counters SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-030 mem_req & mem_ready in RUN SHALL cause no stall (zero-wait access).

Reset
REQ-031 While reset=1, regardless of clk:
- The FSM SHALL be in RUN and the wait counter SHALL be 0.
- mem_timeout=0, stall_count=0, flush_count=0.
- stall, flush, bubble, pc_hold and mem_hold SHALL be 0.
REQ-032 Reset asserted during MEM_WAIT SHALL abandon the wait; the FSM resumes in RUN after deassertion.

Structure
REQ-033 The FSM state encoding and the default MEM_TIMEOUT value SHALL be defined in constants.v alongside CONTROL_SIGNALS_WIDTH.
REQ-034 A single sub-module, sat_counter32 (enable, saturating), SHALL be instantiated twice for the performance counters.
- Hazard detection and the FSM SHALL stay in hazard_controller.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, both valid -> stall=bubble=pc_hold=1 for 1 cycle; stall_count=1.
- x0 load: same as above but ex_rd_addr=0 and id_rs1_addr=0 -> no stall, no bubble.
- Branch + load-use same cycle: ex_branch_taken=1 with a load-use match -> flush=1, stall=0; flush_count=1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> stall=mem_hold=1 for 4 cycles; stall_count=4; mem_timeout=0.
- Timeout: MEM_TIMEOUT=4, mem_ready never asserted -> mem_timeout=1 after the 5th cycle of stall; FSM returns to RUN; flag stays 1 until reset.
- Reset mid-wait: reset pulsed in MEM_WAIT -> all outputs 0 immediately (asynchronously); counters 0; next mem_req=1 with mem_ready=1 -> no stall.
